// File: rtl/carrier_loop_ctrl_if.sv
// carrier_loop_ctrl_if: sample strobe inputs and NCO control / dump outputs of the carrier loop
interface carrier_loop_ctrl_if #(parameter int ACC_W = 12);
  logic sample_en;
  logic sample_in;
  logic lo_sin;
  logic lo_cos;
  logic signed [ACC_W-1:0] i_dump;
  logic signed [ACC_W-1:0] q_dump;
  logic dump_valid;
  logic div_enable;
  logic [1:0] phase;
  logic sync;
  modport master (
    output sample_en, sample_in, lo_sin, lo_cos,
    input  i_dump, q_dump, dump_valid, div_enable, phase, sync
  );
  modport slave (
    input  sample_en, sample_in, lo_sin, lo_cos,
    output i_dump, q_dump, dump_valid, div_enable, phase, sync
  );
endinterface

// File: rtl/carrier_loop_ctrl.sv
// carrier_loop_ctrl: I/Q integrate-and-dump with NCO phase/frequency steering
module carrier_loop_ctrl #(
  parameter int INT_LEN = 1023,
  parameter int ACC_W = 12,
  parameter int THRESH = 8
) (
  input logic clk,
  input logic rst,
  carrier_loop_ctrl_if.slave bus
);
  localparam int CW = $clog2(INT_LEN);
  localparam logic signed [ACC_W-1:0] MAX = ACC_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] TH = ACC_W'(THRESH);
  typedef enum logic [1:0] {S_SYNC, S_RUN, S_EVAL} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic signed [ACC_W-1:0] i_acc, q_acc, i_nxt, q_nxt, i_abs, q_abs;
  logic same, last, take;
  // saturating +/-1 step of each accumulator and magnitude/sign of the last dump
  always_comb begin
    i_nxt = (bus.sample_in == bus.lo_sin) ? ((i_acc == MAX) ? i_acc : i_acc + ONE)
                                          : ((i_acc == -MAX) ? i_acc : i_acc - ONE);
    q_nxt = (bus.sample_in == bus.lo_cos) ? ((q_acc == MAX) ? q_acc : q_acc + ONE)
                                          : ((q_acc == -MAX) ? q_acc : q_acc - ONE);
    i_abs = bus.i_dump[ACC_W-1] ? -bus.i_dump : bus.i_dump;
    q_abs = bus.q_dump[ACC_W-1] ? -bus.q_dump : bus.q_dump;
    same = bus.i_dump[ACC_W-1] == bus.q_dump[ACC_W-1];
    last = count == CW'(INT_LEN - 1);
    take = bus.sample_en && state != S_SYNC;
  end
  // sync pulse, accumulate/dump on strobes, steer the NCO one cycle after each dump
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_SYNC;
      count <= '0;
      i_acc <= '0;
      q_acc <= '0;
      bus.i_dump <= '0;
      bus.q_dump <= '0;
      bus.dump_valid <= 1'b0;
      bus.div_enable <= 1'b0;
      bus.phase <= 2'd0;
      bus.sync <= 1'b0;
    end else begin
      bus.sync <= state == S_SYNC;
      bus.dump_valid <= take && last;
      state <= (take && last) ? S_EVAL : S_RUN;
      if (state == S_EVAL) begin
        bus.phase <= (q_abs > i_abs) ? bus.phase + (same ? 2'd1 : 2'd3) : bus.phase;
        bus.div_enable <= (q_abs > TH) && same;
      end
      if (take) begin
        count <= last ? '0 : count + 1'b1;
        i_acc <= last ? '0 : i_nxt;
        q_acc <= last ? '0 : q_nxt;
        if (last) begin
          bus.i_dump <= i_nxt;
          bus.q_dump <= q_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_carrier_loop_ctrl.sv
// tb_carrier_loop_ctrl: scoreboard bench running a 6-bit and a 4-bit accumulator instance side by side
module tb_carrier_loop_ctrl;
  localparam int N = 8;
  localparam int TH = 2;
  logic clk = 0, rst = 1, sample_en = 0, sample_in = 0, lo_sin = 0, lo_cos = 0;
  always #5 clk = ~clk;
  carrier_loop_ctrl_if #(.ACC_W(6)) b6();
  carrier_loop_ctrl_if #(.ACC_W(4)) b4();
  assign b6.sample_en = sample_en;
  assign b6.sample_in = sample_in;
  assign b6.lo_sin = lo_sin;
  assign b6.lo_cos = lo_cos;
  assign b4.sample_en = sample_en;
  assign b4.sample_in = sample_in;
  assign b4.lo_sin = lo_sin;
  assign b4.lo_cos = lo_cos;
  carrier_loop_ctrl #(.INT_LEN(N), .ACC_W(6), .THRESH(TH)) dut6 (.clk(clk), .rst(rst), .bus(b6));
  carrier_loop_ctrl #(.INT_LEN(N), .ACC_W(4), .THRESH(TH)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  typedef struct {int i6; int q6; int p6; int d6; int i4; int q4; int p4; int d4;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  int acc_i6, acc_q6, acc_i4, acc_q4, cnt, ph6, dv6, ph4, dv4;
  int cyc = 0, dumps = 0, last_dump = 0, gap = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int clamp(int v, int m);
    return v > m ? m : (v < -m ? -m : v);
  endfunction
  function automatic void eval(input int i, input int q, inout int ph, inout int dv);
    int ai = i < 0 ? -i : i;
    int aq = q < 0 ? -q : q;
    bit same = (i >= 0) == (q >= 0);
    if (aq > ai) ph = (ph + (same ? 1 : -1) + 4) % 4;
    dv = (aq > TH && same) ? 1 : 0;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_clear();
    acc_i6 = 0; acc_q6 = 0; acc_i4 = 0; acc_q4 = 0; cnt = 0;
  endtask
  task automatic strobe(input logic s, input logic ls, input logic lc);
    int ti = (s == ls) ? 1 : -1;
    int tq = (s == lc) ? 1 : -1;
    @(negedge clk);
    sample_in = s; lo_sin = ls; lo_cos = lc; sample_en = 1;
    acc_i6 = clamp(acc_i6 + ti, 31); acc_q6 = clamp(acc_q6 + tq, 31);
    acc_i4 = clamp(acc_i4 + ti, 7);  acc_q4 = clamp(acc_q4 + tq, 7);
    cnt++;
    if (cnt == N) begin
      eval(acc_i6, acc_q6, ph6, dv6);
      eval(acc_i4, acc_q4, ph4, dv4);
      sb.push_back('{acc_i6, acc_q6, ph6, dv6, acc_i4, acc_q4, ph4, dv4});
      model_clear();
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_en = 0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; sample_en = 0;
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    model_clear();
    ph6 = 0; dv6 = 0; ph4 = 0; dv4 = 0;
    repeat (3) @(negedge clk);
    chk("rst_out6", {b6.i_dump, b6.q_dump, b6.dump_valid, b6.div_enable, b6.phase, b6.sync}, 0);
    chk("rst_out4", {b4.i_dump, b4.q_dump, b4.dump_valid, b4.div_enable, b4.phase, b4.sync}, 0);
    rst = 0;
    @(negedge clk);
    chk("sync_hi6", b6.sync, 1);
    chk("sync_hi4", b4.sync, 1);
    @(negedge clk);
    chk("sync_lo6", b6.sync, 0);
    chk("phase_rst", b6.phase, 0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (b6.dump_valid || b4.dump_valid) begin
        chk("dv_match", b4.dump_valid, b6.dump_valid);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dump: got dump_valid=1 expected none pending");
        end else begin
          e = sb.pop_front();
          chk("i_dump6", b6.i_dump, e.i6);
          chk("q_dump6", b6.q_dump, e.q6);
          chk("i_dump4", b4.i_dump, e.i4);
          chk("q_dump4", b4.q_dump, e.q4);
          gap = cyc - last_dump;
          last_dump = cyc;
          dumps++;
          @(negedge clk);
          chk("dv_pulse", b6.dump_valid, 0);
          chk("phase6", b6.phase, e.p6);
          chk("div6", b6.div_enable, e.d6);
          chk("phase4", b4.phase, e.p4);
          chk("div4", b4.div_enable, e.d4);
        end
      end
    end
  end
  initial begin : stim
    int d0, pi, pq;
    logic s;
    do_reset();
    for (int k = 0; k < N; k++) begin strobe(1, 1, 1); idle(1); end
    idle(3);
    for (int k = 0; k < N; k++) begin strobe(1, k % 2 == 0, 1); idle(1); end
    idle(3);
    do_reset();
    for (int k = 0; k < N; k++) begin strobe(1, k % 2 == 0, 0); idle(1); end
    idle(3);
    for (int k = 0; k < N; k++) strobe(0, 0, k % 2 == 0);
    idle(3);
    for (int k = 0; k < N; k++) strobe(1, 1, 1);
    for (int k = 0; k < N; k++) strobe(1, 0, 0);
    idle(4);
    do_reset();
    d0 = dumps;
    for (int k = 0; k < 2 * N; k++) strobe(0, 0, 0);
    idle(4);
    chk("cont_dumps", dumps - d0, 2);
    chk("cont_gap", gap, N);
    for (int k = 0; k < 5; k++) strobe(1, 1, 1);
    do_reset();
    d0 = dumps;
    for (int k = 0; k < N; k++) strobe(1, 1, 1);
    idle(4);
    chk("post_rst_dumps", dumps - d0, 1);
    for (int p = 0; p < 40; p++) begin
      pi = $urandom_range(4);
      pq = $urandom_range(4);
      for (int k = 0; k < N; k++) begin
        s = 1'($urandom_range(1));
        strobe(s, ($urandom_range(3) < pi) ? s : !s, ($urandom_range(3) < pq) ? s : !s);
        if ($urandom_range(2) == 0) idle(1);
      end
    end
    idle(4);
    chk("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
